// File: rtl/alu_serial_seq.sv
// alu_serial_seq -- bit-serial WIDTH-bit ALU sequencer around a 1-bit ALU slice.
//
// Latches an operand pair and an opcode on start, feeds the slice one bit per
// clock LSB-first, keeps the slice carry in a flip-flop between bits, and
// reassembles the result word and flags.
//
// Optional feature macro: ALU_SEQ_FLAGS_EN
//   defined   -> zero and overflow are registered outputs
//   undefined -> zero and overflow are tied to 0 (SLT still uses internal ovf)
//
// Ports (alu_serial_seq):
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   start     in   request, sampled only while idle
//   op[1:0]   in   00 AND, 01 OR, 10 ADD/SUB, 11 SLT (signed)
//   sub       in   0 ADD, 1 SUB (op=10 only)
//   a, b      in   WIDTH-bit operands, sampled with start
//   busy      out  high whenever the sequencer is not idle
//   done      out  one-cycle completion pulse
//   result    out  WIDTH-bit result, held until the next completion
//   cout      out  final carry for op=10, else 0
//   zero      out  result == 0
//   overflow  out  signed overflow for op=10, else 0
//
// Ports (alu, 1-bit slice):
//   a, b, cin, add_sub, i3, op[1:0] in; r, co out.
//   op 00 a&b, 01 a|b, 10 a + (b^add_sub) + cin, 11 pass i3.
//   co is always the adder carry, whatever op selects.

module alu (
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic       add_sub,
   input  logic       i3,
   input  logic [1:0] op,
   output logic       r,
   output logic       co
);

   logic bx;
   logic sum;

   always_comb begin
      bx  = b ^ add_sub;
      sum = a ^ bx ^ cin;
      co  = (a & bx) | (a & cin) | (bx & cin);
      unique case (op)
         2'b00:   r = a & b;
         2'b01:   r = a | b;
         2'b10:   r = sum;
         default: r = i3;
      endcase
   end

endmodule

module alu_serial_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero,
   output logic             overflow
);

   localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] a_sr_q, b_sr_q;
   logic [WIDTH-2:0] res_sr_q, res_sr_d;   // bits already produced, filled from the top
   logic [1:0]       op_q;
   logic             sub_q;
   logic             carry_q;
   logic [CntW-1:0]  cnt_q;
   logic [WIDTH-1:0] result_q;
   logic             cout_q;

   logic             slice_r, slice_co, slice_as;
   logic [1:0]       slice_op;
   logic             accept, last;
   logic             ovf, less;
   logic [WIDTH-1:0] new_result;

   // SLT runs the slice as a subtract; the sign of A-B is fixed up with ovf below.
   assign slice_op = (op_q == 2'b11) ? 2'b10 : op_q;
   assign slice_as = (op_q == 2'b11) ? 1'b1 : sub_q;

   alu u_slice (
      .a       (a_sr_q[0]),
      .b       (b_sr_q[0]),
      .cin     (carry_q),
      .add_sub (slice_as),
      .i3      (1'b0),
      .op      (slice_op),
      .r       (slice_r),
      .co      (slice_co)
   );

   assign accept = (state_q == StIdle) && start;
   assign last   = (state_q == StRun) && (cnt_q == CntLast);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (cnt_q == CntLast) state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      res_sr_d           = res_sr_q >> 1;
      res_sr_d[WIDTH-2]  = slice_r;
      // Only meaningful on the MSB cycle: carry into vs. out of the sign bit.
      ovf                = carry_q ^ slice_co;
      less               = slice_r ^ ovf;
      new_result         = {slice_r, res_sr_q};
      if (op_q == 2'b11) begin
         new_result      = '0;
         new_result[0]   = less;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         res_sr_q <= '0;
         op_q     <= '0;
         sub_q    <= 1'b0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_sr_q   <= a;
            b_sr_q   <= b;
            op_q     <= op;
            sub_q    <= sub;
            cnt_q    <= '0;
            carry_q  <= (op == 2'b11) ? 1'b1 : sub;
         end else if (state_q == StRun) begin
            a_sr_q   <= a_sr_q >> 1;
            b_sr_q   <= b_sr_q >> 1;
            res_sr_q <= res_sr_d;
            carry_q  <= slice_co;
            cnt_q    <= cnt_q + 1'b1;
         end
         if (last) begin
            result_q <= new_result;
            cout_q   <= (op_q == 2'b10) ? slice_co : 1'b0;
         end
      end
   end

`ifdef ALU_SEQ_FLAGS_EN
   logic zero_q, ovf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (last) begin
         zero_q <= (new_result == '0);
         ovf_q  <= (op_q == 2'b10) ? ovf : 1'b0;
      end
   end

   assign zero     = zero_q;
   assign overflow = ovf_q;
`else
   assign zero     = 1'b0;
   assign overflow = 1'b0;
`endif

   assign busy   = (state_q != StIdle);
   assign done   = (state_q == StDone);
   assign result = result_q;
   assign cout   = cout_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq: directed cases plus randomized
// operations compared against an arithmetic reference model.

module tb_alu_serial_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   op = '0;
   logic         sub = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, cout, zero, overflow;
   logic [W-1:0] result;

   int checks = 0;
   int errors = 0;

   alu_serial_seq #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .zero     (zero),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain signed/unsigned arithmetic on whole words.
   function automatic void model(input logic [1:0] m_op, input logic m_sub,
                                 input logic [W-1:0] m_a, input logic [W-1:0] m_b,
                                 output logic [W-1:0] m_res, output logic m_cout,
                                 output logic m_zero, output logic m_ovf);
      longint ua, ub, sa, sb, s, smax, smin;
      ua     = longint'(m_a);
      ub     = longint'(m_b);
      sa     = longint'($signed(m_a));
      sb     = longint'($signed(m_b));
      smax   = (longint'(1) <<< (W - 1)) - 1;
      smin   = -(longint'(1) <<< (W - 1));
      m_cout = 1'b0;
      m_ovf  = 1'b0;
      case (m_op)
         2'b00: m_res = m_a & m_b;
         2'b01: m_res = m_a | m_b;
         2'b10: begin
            s      = m_sub ? sa - sb : sa + sb;
            m_res  = W'(m_sub ? ua - ub : ua + ub);
            m_cout = m_sub ? (ua >= ub) : (ua + ub >= (longint'(1) <<< W));
            m_ovf  = (s > smax) || (s < smin);
         end
         default: m_res = (sa < sb) ? W'(1) : W'(0);
      endcase
      m_zero = (m_res == '0);
`ifndef ALU_SEQ_FLAGS_EN
      m_zero = 1'b0;
      m_ovf  = 1'b0;
`endif
   endfunction

   // One operation; optionally pulses start again mid-run with other operands.
   task automatic run_op(input string name, input logic [1:0] t_op, input logic t_sub,
                         input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                         input bit mid_start);
      logic [W-1:0] e_res;
      logic         e_cout, e_zero, e_ovf;
      int           n_done, first;
      model(t_op, t_sub, t_a, t_b, e_res, e_cout, e_zero, e_ovf);
      @(negedge clk);
      start = 1'b1; op = t_op; sub = t_sub; a = t_a; b = t_b;
      @(posedge clk);   // E0
      #1;
      check({name, "_busy_e0"}, busy, 1);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); op = 2'($urandom); sub = 1'($urandom);
      n_done = 0;
      first  = -1;
      for (int k = 1; k <= W + 3; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            n_done++;
            if (first < 0) first = k;
         end
         check({name, "_busy"}, busy, (k <= W) ? 1 : 0);
         if (mid_start && k == 3) begin
            start = 1'b1; op = 2'b10; sub = 1'b0; a = 8'h55; b = 8'h0F;
         end else begin
            start = 1'b0;
         end
      end
      check({name, "_done_lat"}, first, W);
      check({name, "_done_cnt"}, n_done, 1);
      check({name, "_result"}, result, e_res);
      check({name, "_cout"}, cout, e_cout);
      check({name, "_zero"}, zero, e_zero);
      check({name, "_ovf"}, overflow, e_ovf);
   endtask

   task automatic reset_mid_op();
      int n_done;
      @(negedge clk);
      start = 1'b1; op = 2'b10; sub = 1'b0; a = 8'h55; b = 8'h11;
      @(posedge clk);   // E0
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);   // E1..E3
      #1;
      rst = 1'b1;                  // sampled at E4, where bit 3 would be processed
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_result", result, 0);
      check("rst_mid_cout", cout, 0);
      check("rst_mid_zero", zero, 0);
      check("rst_mid_ovf", overflow, 0);
      n_done = 0;
      for (int k = 0; k < W + 3; k++) begin
         @(posedge clk);
         #1;
         if (done) n_done++;
      end
      check("rst_mid_no_done", n_done, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_cout", cout, 0);
      check("rst_zero", zero, 0);
      check("rst_ovf", overflow, 0);
      @(negedge clk);
      rst = 1'b0;

      run_op("add_ovf", 2'b10, 1'b0, 8'h7F, 8'h01, 1'b0);
      run_op("sub_zero", 2'b10, 1'b1, 8'h05, 8'h05, 1'b0);
      run_op("and", 2'b00, 1'b0, 8'hF0, 8'h3C, 1'b0);
      run_op("or", 2'b01, 1'b0, 8'hF0, 8'h3C, 1'b0);
      run_op("slt_neg", 2'b11, 1'b0, 8'h80, 8'h01, 1'b0);
      run_op("slt_pos", 2'b11, 1'b0, 8'h01, 8'h80, 1'b0);
      run_op("slt_ovf", 2'b11, 1'b0, 8'h7F, 8'h80, 1'b0);
      run_op("mid_start", 2'b10, 1'b0, 8'h10, 8'h20, 1'b1);
      check("mid_start_val", result, 8'h30);
      reset_mid_op();
      run_op("after_rst", 2'b10, 1'b0, 8'h01, 8'h01, 1'b0);
      check("after_rst_val", result, 8'h02);

      for (int i = 0; i < 40; i++) begin
         logic [1:0]   r_op;
         logic         r_sub;
         logic [W-1:0] r_a, r_b;
         r_op  = 2'($urandom_range(0, 3));
         r_sub = 1'($urandom_range(0, 1));
         r_a   = W'($urandom);
         r_b   = W'($urandom);
         if (i % 8 == 0) r_b = r_a;   // exercise zero results and equal-operand SLT
         run_op("rand", r_op, r_sub, r_a, r_b, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
